isp_raw_tpg: RTL and testbench

//  Bayer raw test-pattern generator and video-timing source. Drives the

---
 rtl/isp_raw_tpg.sv | 268 ++++++++++++++++++++++++++
 tb/tb_isp_raw_tpg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_raw_tpg.sv
// isp_raw_tpg: Bayer raw test-pattern generator and video-timing source.
// It produces vsync / vblank / active-line timing and one of four patterns:
// flat grey, horizontal ramp, colour bars or CFA-ID.
// Optional build macro: ISP_TPG_NOISE_EN adds per-pixel LFSR noise in the
// range -4..+3, saturated to the pixel range. It reseeds at every frame start.
module isp_raw_tpg #(
  parameter int unsigned BITS        = 8,
  parameter int unsigned WIDTH       = 1280,
  parameter int unsigned HEIGHT      = 960,
  parameter int unsigned BAYER       = 0,
  parameter int unsigned H_BLANK     = 160,
  parameter int unsigned V_BLANK     = 20,
  parameter int unsigned VSYNC_LINES = 2
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [1:0]      pattern,
  output logic            busy,
  output logic            out_href,
  output logic            out_vsync,
  output logic            out_de,
  output logic [BITS-1:0] out_raw
);

  localparam int unsigned LINE_LEN = WIDTH + H_BLANK;
  localparam int unsigned H_W      = $clog2(LINE_LEN);
  localparam int unsigned V_MAX0   = (HEIGHT > V_BLANK) ? HEIGHT : V_BLANK;
  localparam int unsigned V_MAX    = (V_MAX0 > VSYNC_LINES) ? V_MAX0 : VSYNC_LINES;
  localparam int unsigned V_W      = $clog2(V_MAX + 1);
  localparam int unsigned BAR_W    = WIDTH / 8;
  localparam int unsigned BP_W     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [H_W-1:0]  H_LAST   = H_W'(LINE_LEN - 1);
  localparam logic [H_W-1:0]  H_ACT    = H_W'(WIDTH);
  localparam logic [V_W-1:0]  VS_LAST  = V_W'((VSYNC_LINES > 0) ? VSYNC_LINES - 1 : 0);
  localparam logic [V_W-1:0]  VB_LAST  = V_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  localparam logic [V_W-1:0]  ACT_LAST = V_W'((HEIGHT > 0) ? HEIGHT - 1 : 0);
  localparam logic [BP_W-1:0] BP_LAST  = BP_W'((BAR_W > 0) ? BAR_W - 1 : 0);
  localparam logic [BITS-1:0] PIX_MAX  = {BITS{1'b1}};
  localparam logic [BITS-1:0] PIX_MID  = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] PIX_MIDM = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [1:0]      PHASE    = 2'(BAYER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VSYNC  = 2'd1,
    S_VBLANK = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [H_W-1:0]  h_q, h_d;
  logic [V_W-1:0]  v_q, v_d;
  logic [1:0]      pat_q, pat_d;
  logic [BP_W-1:0] bar_pos_q, bar_pos_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic            line_end;
  logic [H_W-1:0]  h_inc;

  logic            busy_d, href_d, vsync_d;
  logic [1:0]      fmt;
  logic [2:0]      bar_rgb;
  logic            bar_on;
  logic [BITS-1:0] base_pix;
  logic [BITS-1:0] pix_val;
  logic [BITS-1:0] raw_d;

  // Colour-bar R/G/B on-flags: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // FSM state register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, counters and pattern latch; outputs are derived from the next values.
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    pat_d    = pat_q;
    line_end = (h_q == H_LAST);
    h_inc    = line_end ? '0 : h_q + H_W'(1);
    case (state_q)
      S_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) begin
          state_d = S_VSYNC;
          pat_d   = pattern;
        end
      end
      S_VSYNC: begin
        h_d = h_inc;
        if (line_end) begin
          if (v_q == VS_LAST) begin
            v_d     = '0;
            state_d = (V_BLANK == 0) ? S_ACTIVE : S_VBLANK;
          end else begin
            v_d = v_q + V_W'(1);
          end
        end
      end
      S_VBLANK: begin
        h_d = h_inc;
        if (line_end) begin
          if (v_q == VB_LAST) begin
            v_d     = '0;
            state_d = S_ACTIVE;
          end else begin
            v_d = v_q + V_W'(1);
          end
        end
      end
      S_ACTIVE: begin
        h_d = h_inc;
        if (line_end) begin
          if (v_q == ACT_LAST) begin
            v_d = '0;
            if (enable) begin
              state_d = S_VSYNC;
              pat_d   = pattern;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            v_d = v_q + V_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_ACTIVE) && (h_d < H_ACT);
  end

  // Bar position tracks h_d so the bar index is available without a divider.
  always_comb begin
    bar_pos_d = bar_pos_q;
    bar_idx_d = bar_idx_q;
    if (h_d == '0) begin
      bar_pos_d = '0;
      bar_idx_d = '0;
    end else if (bar_pos_q == BP_LAST) begin
      bar_pos_d = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_pos_d = bar_pos_q + BP_W'(1);
    end
  end

  // Counter, pattern and bar registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      pat_q     <= '0;
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      pat_q     <= pat_d;
      bar_pos_q <= bar_pos_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Pattern pixel for the position being presented next cycle.
  always_comb begin
    fmt     = PHASE ^ {v_d[0], h_d[0]};
    bar_rgb = bar_flags(bar_idx_d);
    case (fmt)
      2'd0:    bar_on = bar_rgb[2];
      2'd3:    bar_on = bar_rgb[0];
      default: bar_on = bar_rgb[1];
    endcase
    case (pat_d)
      2'd0:    base_pix = PIX_MID;
      2'd1:    base_pix = BITS'(h_d);
      2'd2:    base_pix = bar_on ? PIX_MAX : '0;
      default: begin
        case (fmt)
          2'd0:    base_pix = PIX_MAX;
          2'd1:    base_pix = PIX_MID;
          2'd2:    base_pix = PIX_MIDM;
          default: base_pix = '0;
        endcase
      end
    endcase
  end

`ifdef ISP_TPG_NOISE_EN
  localparam int unsigned SUM_W     = BITS + 2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0]      lfsr_q, lfsr_d;
  logic             frame_start;
  logic [SUM_W-1:0] noisy_sum;

  // LFSR reseeds on VSYNC entry and steps only on active pixels.
  always_comb begin
    frame_start = (state_d == S_VSYNC) && (state_q != S_VSYNC);
    lfsr_d      = lfsr_q;
    if (frame_start) begin
      lfsr_d = LFSR_SEED;
    end else if (href_d) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // LFSR register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  // Add offset lfsr[2:0]-4 and clamp to [0, MAX].
  always_comb begin
    noisy_sum = {2'b00, base_pix} + SUM_W'(lfsr_q[2:0]);
    if (noisy_sum < SUM_W'(4)) begin
      pix_val = '0;
    end else if ((noisy_sum - SUM_W'(4)) > {2'b00, PIX_MAX}) begin
      pix_val = PIX_MAX;
    end else begin
      pix_val = BITS'(noisy_sum - SUM_W'(4));
    end
  end
`else
  // Without noise the pattern value is passed through unchanged.
  always_comb pix_val = base_pix;
`endif

  // Raw is forced to 0 outside active pixels.
  always_comb raw_d = href_d ? pix_val : '0;

  // Registered outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_de    <= 1'b0;
      out_raw   <= '0;
    end else begin
      busy      <= busy_d;
      out_href  <= href_d;
      out_vsync <= vsync_d;
      out_de    <= href_d;
      out_raw   <= raw_d;
    end
  end

endmodule

// File: tb/tb_isp_raw_tpg.sv
// Directed bench for isp_raw_tpg: frame timing, all four patterns, both Bayer
// phases, mid-frame enable/pattern changes and asynchronous reset.
`timescale 1ns/1ps
module tb_isp_raw_tpg;

  localparam int unsigned BITS        = 8;
  localparam int unsigned WIDTH       = 16;
  localparam int unsigned HEIGHT      = 4;
  localparam int unsigned H_BLANK     = 4;
  localparam int unsigned V_BLANK     = 2;
  localparam int unsigned VSYNC_LINES = 1;
  localparam int LINE  = 20;
  localparam int FRAME = 140;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern = 2'd0;

  logic       busy, href, vsync, de;
  logic [7:0] raw;
  logic       busy_b, href_b, vsync_b, de_b;
  logic [7:0] raw_b;

  always #5 clk = ~clk;

  isp_raw_tpg #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BAYER(0),
                .H_BLANK(H_BLANK), .V_BLANK(V_BLANK), .VSYNC_LINES(VSYNC_LINES)) dut (
    .pclk(clk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
    .busy(busy), .out_href(href), .out_vsync(vsync), .out_de(de), .out_raw(raw));

  isp_raw_tpg #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BAYER(3),
                .H_BLANK(H_BLANK), .V_BLANK(V_BLANK), .VSYNC_LINES(VSYNC_LINES)) dut_b (
    .pclk(clk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
    .busy(busy_b), .out_href(href_b), .out_vsync(vsync_b), .out_de(de_b), .out_raw(raw_b));

  int compared = 0;
  int mismatched = 0;

  logic [7:0] pix  [4][16];
  logic [7:0] pixb [4][16];
  int vs_len, first_href, edges, spacing_bad, de_bad, blank_bad, busy_low, align_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pix_ok(input logic [7:0] got, input logic [7:0] exp);
`ifdef ISP_TPG_NOISE_EN
    int lo;
    int hi;
    lo = (exp < 8'd4) ? 0 : int'(exp) - 4;
    hi = (exp > 8'd252) ? 255 : int'(exp) + 3;
    return !$isunknown(got) && (int'(got) >= lo) && (int'(got) <= hi);
`else
    return got === exp;
`endif
  endfunction

  task automatic check_px(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (pix_ok(got, exp)) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int pat, input int bayer, input int l, input int c);
    logic [1:0] fmt;
    logic [2:0] rgb;
    logic       on;
    fmt = 2'(bayer) ^ {l[0], c[0]};
    case (c / 2)
      0: rgb = 3'b111;
      1: rgb = 3'b110;
      2: rgb = 3'b011;
      3: rgb = 3'b010;
      4: rgb = 3'b101;
      5: rgb = 3'b100;
      6: rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    on = (fmt == 2'd0) ? rgb[2] : (fmt == 2'd3) ? rgb[0] : rgb[1];
    case (pat)
      0: return 8'h80;
      1: return 8'(c);
      2: return on ? 8'hFF : 8'h00;
      default: begin
        case (fmt)
          2'd0: return 8'hFF;
          2'd1: return 8'h80;
          2'd2: return 8'h7F;
          default: return 8'h00;
        endcase
      end
    endcase
  endfunction

  // Wait (bounded) for vsync, then record one frame window of FRAME cycles.
  task automatic capture(input int pat_at, input logic [1:0] new_pat, input int en_off_at,
                         output bit got_frame);
    int   t;
    int   last;
    int   col;
    logic prev;
    t = 0; last = 0; col = 0; prev = 1'b0;
    vs_len = 0; first_href = -1; edges = 0; spacing_bad = 0;
    de_bad = 0; blank_bad = 0; busy_low = 0; align_bad = 0;
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 16; c++) begin
        pix[l][c]  = 'x;
        pixb[l][c] = 'x;
      end
    while (vsync !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    got_frame = (vsync === 1'b1);
    if (!got_frame) return;
    for (int i = 0; i < FRAME; i++) begin
      if (i == pat_at) pattern = new_pat;
      if (i == en_off_at) enable = 1'b0;
      if (vsync === 1'b1) vs_len++;
      if (busy !== 1'b1) busy_low++;
      if (de !== href || de_b !== href_b) de_bad++;
      if (href_b !== href || vsync_b !== vsync) align_bad++;
      if (href !== 1'b1 && raw !== 8'h00) blank_bad++;
      if (href_b !== 1'b1 && raw_b !== 8'h00) blank_bad++;
      if (href === 1'b1 && prev !== 1'b1) begin
        if (first_href < 0) first_href = i;
        else if (i - last != LINE) spacing_bad++;
        last = i;
        edges++;
        col = 0;
      end
      if (href === 1'b1 && edges >= 1 && edges <= 4 && col < 16) begin
        pix[edges-1][col]  = raw;
        pixb[edges-1][col] = raw_b;
        col++;
      end
      prev = href;
      @(negedge clk);
    end
  endtask

  task automatic frame_stats(input string tag, input bit got_frame);
    check({tag, ".found"}, got_frame, 1);
    check({tag, ".vs_len"}, vs_len, 20);
    check({tag, ".first_href"}, first_href, 60);
    check({tag, ".edges"}, edges, 4);
    check({tag, ".spacing"}, spacing_bad, 0);
    check({tag, ".de_eq_href"}, de_bad, 0);
    check({tag, ".blank_raw"}, blank_bad, 0);
    check({tag, ".busy"}, busy_low, 0);
    check({tag, ".align"}, align_bad, 0);
  endtask

  task automatic verify(input string tag, input int pat);
    int bad;
    int badb;
    bad = 0; badb = 0;
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 16; c++) begin
        if (!pix_ok(pix[l][c], exp_pix(pat, 0, l, c))) bad++;
        if (!pix_ok(pixb[l][c], exp_pix(pat, 3, l, c))) badb++;
      end
    check({tag, ".pix_bad"}, bad, 0);
    check({tag, ".pixb_bad"}, badb, 0);
  endtask

  initial begin
    bit ok;
    int nv;
    int t;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.href", href, 0);
    check("rst.vsync", vsync, 0);
    check("rst.de", de, 0);
    check("rst.raw", raw, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.busy", busy, 0);
    check("idle.vsync", vsync, 0);

    // Frame 1: flat grey; pattern switched to ramp mid-frame (must not show)
    pattern = 2'd0;
    enable  = 1'b1;
    capture(70, 2'd1, -1, ok);
    frame_stats("f1", ok);
    verify("f1", 0);
    check_px("f1.p0_0", pix[0][0], 8'h80);
    check_px("f1.p3_15", pix[3][15], 8'h80);

    // Frame 2: h-ramp latched at vsync; switch to CFA-ID mid-frame
    capture(30, 2'd3, -1, ok);
    frame_stats("f2", ok);
    verify("f2", 1);
    check_px("f2.p1_0", pix[1][0], 8'h00);
    check_px("f2.p2_15", pix[2][15], 8'h0F);
    check_px("f2.p0_7", pix[0][7], 8'h07);

    // Frame 3: CFA-ID for both Bayer phases; switch to bars mid-frame
    capture(30, 2'd2, -1, ok);
    frame_stats("f3", ok);
    verify("f3", 3);
    check_px("f3.r0c0", pix[0][0], 8'hFF);
    check_px("f3.r0c1", pix[0][1], 8'h80);
    check_px("f3.r1c0", pix[1][0], 8'h7F);
    check_px("f3.r1c1", pix[1][1], 8'h00);
    check_px("f3.b.r0c0", pixb[0][0], 8'h00);
    check_px("f3.b.r0c1", pixb[0][1], 8'h7F);
    check_px("f3.b.r1c0", pixb[1][0], 8'h80);
    check_px("f3.b.r1c1", pixb[1][1], 8'hFF);

    // Frame 4: colour bars; enable dropped mid-frame, frame must still complete
    capture(30, 2'd0, 80, ok);
    frame_stats("f4", ok);
    verify("f4", 2);
    check_px("f4.p0", pix[0][0], 8'hFF);
    check_px("f4.p1", pix[0][1], 8'hFF);
    check_px("f4.p4_r", pix[0][4], 8'h00);
    check_px("f4.p5_g", pix[0][5], 8'hFF);
    check_px("f4.l1p4_g", pix[1][4], 8'hFF);
    check_px("f4.p14", pix[0][14], 8'h00);
    check_px("f4.p15", pix[0][15], 8'h00);
    check("f4.busy_end", busy, 0);
    nv = 0;
    repeat (200) begin
      if (vsync === 1'b1) nv++;
      @(negedge clk);
    end
    check("f4.no_vsync", nv, 0);
    check("f4.idle_busy", busy, 0);

    // Asynchronous reset in the middle of an active line
    pattern = 2'd1;
    enable  = 1'b1;
    t = 0;
    while (href !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("ar.href_seen", href, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar.busy", busy, 0);
    check("ar.href", href, 0);
    check("ar.vsync", vsync, 0);
    check("ar.de", de, 0);
    check("ar.raw", raw, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame restarts from VSYNC after release
    capture(-1, 2'd0, 100, ok);
    frame_stats("f5", ok);
    verify("f5", 1);
    check("f5.busy_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
